// File: rtl/parity_frame_rx.sv
// Serial start/data/parity/stop frame receiver. Deserialises one bit per clock
// LSB-first and checks the received parity against the XOR of the data bits.
module parity_frame_rx #(
  parameter int DATA_W = 3,
  parameter int ODD    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              perr,
  output logic              ferr,
  output logic              busy
);
  localparam int   CW    = $clog2(DATA_W + 1);
  localparam logic ODD_B = (ODD != 0);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] data_q, shift_d;
  logic              acc_q, par_q;
  logic [DATA_W-1:0] out_q;
  logic              valid_q, perr_q, ferr_q;

  // New bits enter at the MSB so the first data bit ends up at bit 0.
  always_comb begin
    shift_d             = data_q >> 1;
    shift_d[DATA_W-1]   = in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      acc_q   <= 1'b0;
      par_q   <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!in) begin
            data_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            state_q <= DATA;
          end
        end
        DATA: begin
          data_q <= shift_d;
          acc_q  <= acc_q ^ in;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) state_q <= PARITY;
        end
        PARITY: begin
          par_q   <= in;
          state_q <= STOP;
        end
        STOP: begin
          // A bad stop bit still reports the frame; ferr flags it.
          out_q   <= data_q;
          perr_q  <= acc_q ^ par_q ^ ODD_B;
          ferr_q  <= ~in;
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign perr      = perr_q;
  assign ferr      = ferr_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: even and odd instances share one serial line;
// expected frames are queued at stimulus time and popped on each out_valid.
module tb_parity_frame_rx;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in = 1'b1;
  logic [W-1:0] out_e, out_o;
  logic v_e, v_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

  parity_frame_rx #(.DATA_W(W), .ODD(0)) dut_even (
    .clk(clk), .rst_n(rst_n), .in(in), .out(out_e), .out_valid(v_e),
    .perr(perr_e), .ferr(ferr_e), .busy(busy_e));
  parity_frame_rx #(.DATA_W(W), .ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .in(in), .out(out_o), .out_valid(v_o),
    .perr(perr_o), .ferr(ferr_o), .busy(busy_o));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] out;
    logic perr_e, perr_o, ferr;
    int   cyc;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [W-1:0] w;
    logic par, stop;
    logic [W-1:0] exp_out;
    logic exp_perr_e, exp_perr_o, exp_ferr;
    int   gap;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every pulse must match the oldest queued frame, on its cycle.
  always @(negedge clk) begin
    if (v_e || v_o) begin
      chk("valid_pair", {v_e, v_o}, 2'b11);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_even", out_e, e.out);
        chk("out_odd", out_o, e.out);
        chk("perr_even", perr_e, e.perr_e);
        chk("perr_odd", perr_o, e.perr_o);
        chk("ferr", {ferr_e, ferr_o}, {e.ferr, e.ferr});
        chk("valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic par, input logic stop,
                            input logic [W-1:0] eo, input logic pe, input logic po,
                            input logic fe);
    exp_t e;
    @(negedge clk);
    // Start bit is sampled at edge cyc+1; results appear W+2 edges later.
    e.out = eo; e.perr_e = pe; e.perr_o = po; e.ferr = fe; e.cyc = cyc + 1 + W + 2;
    exp_q.push_back(e);
    in = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      in = w[i];
    end
    @(negedge clk);
    in = par;
    @(negedge clk);
    in = stop;
  endtask

  vec_t vecs[5];
  int   bad;

  initial begin
    // Words listed with bit 0 = first bit on the line.
    vecs[0] = '{w: 3'b101, par: 1'b0, stop: 1'b1, exp_out: 3'b101,
                exp_perr_e: 1'b0, exp_perr_o: 1'b1, exp_ferr: 1'b0, gap: 0};
    vecs[1] = '{w: 3'b011, par: 1'b1, stop: 1'b1, exp_out: 3'b011,
                exp_perr_e: 1'b1, exp_perr_o: 1'b0, exp_ferr: 1'b0, gap: 2};
    vecs[2] = '{w: 3'b100, par: 1'b1, stop: 1'b0, exp_out: 3'b100,
                exp_perr_e: 1'b0, exp_perr_o: 1'b1, exp_ferr: 1'b1, gap: 1};
    vecs[3] = '{w: 3'b010, par: 1'b1, stop: 1'b0, exp_out: 3'b010,
                exp_perr_e: 1'b0, exp_perr_o: 1'b1, exp_ferr: 1'b1, gap: 0};
    vecs[4] = '{w: 3'b110, par: 1'b0, stop: 1'b1, exp_out: 3'b110,
                exp_perr_e: 1'b0, exp_perr_o: 1'b1, exp_ferr: 1'b0, gap: 1};

    #1;
    chk("reset_outputs", {out_e, v_e, perr_e, ferr_e, busy_e},
        {3'b000, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_outputs_odd", {out_o, v_o, perr_o, ferr_o, busy_o},
        {3'b000, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Vector 3 follows a low stop bit with an immediate start bit.
    foreach (vecs[i]) begin
      send_frame(vecs[i].w, vecs[i].par, vecs[i].stop, vecs[i].exp_out,
                 vecs[i].exp_perr_e, vecs[i].exp_perr_o, vecs[i].exp_ferr);
      idle(vecs[i].gap);
    end
    idle(3);

    for (int k = 0; k < 8; k++) begin
      logic [W-1:0] w;
      w = W'(k);
      send_frame(w, ^w, 1'b1, w, 1'b0, 1'b1, 1'b0);
    end
    idle(3);

    // Reset during the second data bit discards the frame.
    @(negedge clk); in = 1'b0;
    @(negedge clk); in = 1'b0;
    @(negedge clk); in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {out_e, v_e, perr_e, ferr_e, busy_e},
        {3'b000, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("midreset_outputs_odd", {out_o, v_o, perr_o, ferr_o, busy_o},
        {3'b000, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk); in = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    send_frame(3'b110, 1'b0, 1'b1, 3'b110, 1'b0, 1'b1, 1'b0);

    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      in = 1'b1;
      if (i >= 10 && (v_e || busy_e || v_o || busy_o || out_e != 3'b110)) bad++;
    end
    chk("idle_50_quiet", bad, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("frames_outstanding", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
